// File: rtl/ttl_sched_pkg.sv
// ttl_sched_pkg: shared types and field positions for the TTL event scheduler.
// An event word is {fire time[127:64], payload[63:0]}; payload bit 0 is the TTL level.
package ttl_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_FIRE = 2'd3
   } ttl_sched_state_t;

   localparam int TS_MSB      = 127;
   localparam int TS_LSB      = 64;
   localparam int PAYLOAD_MSB = 63;

   typedef logic [127:0] ttl_event_t;

   function automatic logic [63:0] event_ts(input ttl_event_t ev);
      return ev[TS_MSB:TS_LSB];
   endfunction

endpackage

// File: rtl/ttl_event_fifo.sv
// ttl_event_fifo: synchronous event FIFO with occupancy count and flush.
// Head word is read combinationally so the scheduler can evaluate it in the pop cycle.
module ttl_event_fifo
   import ttl_sched_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_flush,
   input  logic             i_push,
   input  ttl_event_t       i_data,
   input  logic             i_pop,
   output ttl_event_t       o_head,
   output logic [CW-1:0]    o_count,
   output logic             o_full
);

   ttl_event_t       r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !i_flush;
   assign w_pop   = i_pop && !i_flush;
   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));

   // Storage array; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ttl_event_scheduler.sv
// ttl_event_scheduler: releases buffered timed events to one TTL channel controller
// exactly when the global timestamp reaches each event's fire time.
// Build option: define TTL_SCHED_LATE_DROP_EN to drop late events; by default a late
// event is fired as soon as possible. Both cases flag late_error and bump late_count.
//
//   state | meaning
//   IDLE  | nothing held, waiting for the FIFO to become non-empty
//   LOAD  | pop head into hold register, decide late / wait
//   WAIT  | holding an event, waiting for timestamp + 1 == hold_ts
//   FIRE  | counter_matched high, gpo_in valid for this single cycle
module ttl_event_scheduler
   import ttl_sched_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int LATE_CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [63:0]               timestamp,
   input  logic                      wr_valid,
   input  logic [127:0]              wr_data,
   output logic                      wr_ready,
   input  logic                      flush,
   input  logic                      override_active,
   output logic [127:0]              gpo_in,
   output logic                      counter_matched,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      late_error,
   output logic [LATE_CNT_W-1:0]     late_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   ttl_sched_state_t        r_state;
   logic [63:0]             r_hold_ts;
   logic [63:0]             r_hold_payload;
   logic [127:0]            r_gpo_in;
   logic                    r_counter_matched;
   logic                    r_late_error;
   logic [LATE_CNT_W-1:0]   r_late_count;

   ttl_event_t              w_head;
   logic [CW-1:0]           w_count;
   logic                    w_full;
   logic                    w_push;
   logic                    w_pop;
   logic [63:0]             w_ts_next;
   logic                    w_head_late;
   logic                    w_match;
   logic                    w_late_event;

   assign w_push      = wr_valid && !w_full && !flush;
   assign w_pop       = (r_state == ST_LOAD) && !flush;
   assign w_ts_next   = timestamp + 64'd1;
   assign w_head_late = (event_ts(w_head) <= w_ts_next);
   assign w_match     = (r_hold_ts == w_ts_next);
   assign w_late_event = !flush &&
                         (((r_state == ST_LOAD) && w_head_late) ||
                          ((r_state == ST_WAIT) && w_match && override_active));

   assign wr_ready        = !w_full;
   assign fifo_count      = w_count;
   assign gpo_in          = r_gpo_in;
   assign counter_matched = r_counter_matched;
   assign late_error      = r_late_error;
   assign late_count      = r_late_count;

   ttl_event_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (flush),
      .i_push  (w_push),
      .i_data  (wr_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full)
   );

   // Scheduling FSM; fire strobe is registered one cycle ahead so it lands on timestamp == hold_ts.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state           <= ST_IDLE;
         r_hold_ts         <= '0;
         r_hold_payload    <= '0;
         r_gpo_in          <= '0;
         r_counter_matched <= 1'b0;
      end else begin
         r_counter_matched <= 1'b0;
         if (flush) begin
            r_state        <= ST_IDLE;
            r_hold_ts      <= '0;
            r_hold_payload <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_count != '0) r_state <= ST_LOAD;
               end
               ST_LOAD: begin
                  r_hold_ts      <= event_ts(w_head);
                  r_hold_payload <= w_head[PAYLOAD_MSB:0];
                  if (w_head_late) begin
`ifdef TTL_SCHED_LATE_DROP_EN
                     // count still includes the entry being popped
                     r_state <= (w_count >= CW'(2)) ? ST_LOAD : ST_IDLE;
`else
                     r_state           <= ST_FIRE;
                     r_counter_matched <= 1'b1;
                     r_gpo_in          <= w_head;
`endif
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (w_match) begin
                     if (override_active) begin
                        r_state <= (w_count != '0) ? ST_LOAD : ST_IDLE;
                     end else begin
                        r_state           <= ST_FIRE;
                        r_counter_matched <= 1'b1;
                        r_gpo_in          <= {r_hold_ts, r_hold_payload};
                     end
                  end
               end
               ST_FIRE: begin
                  r_state <= (w_count != '0) ? ST_LOAD : ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Late-event pulse and saturating count; only reset clears the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_late_error <= 1'b0;
         r_late_count <= '0;
      end else begin
         r_late_error <= w_late_event;
         if (w_late_event && (r_late_count != '1)) begin
            r_late_count <= r_late_count + LATE_CNT_W'(1);
         end
      end
   end

endmodule
